// File: rtl/alu_result_stage_pkg.sv
// Shared opcode encodings, result-kind encoding and the opcode classifier
// used by the ALU result stage.
package alu_result_stage_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;

  typedef enum logic [1:0] {
    KIND_GPR  = 2'd0,
    KIND_HILO = 2'd1,
    KIND_MAR  = 2'd2,
    KIND_PC   = 2'd3
  } kind_t;

  typedef struct packed {
    kind_t kind;
    logic  drop;
  } class_t;

  // Opcodes outside every sink group (including 13, 14 and 20+) are dropped.
  function automatic class_t classify(input logic [4:0] op);
    class_t c;
    c.kind = KIND_GPR;
    c.drop = 1'b0;
    if (op == OP_LD || op == OP_ST)
      c.kind = KIND_MAR;
    else if (op == OP_MUL || op == OP_DIV)
      c.kind = KIND_HILO;
    else if (op == OP_BR)
      c.kind = KIND_PC;
    else if (op inside {OP_LDI, [OP_ADD:OP_ADDI], OP_NEG, OP_NOT})
      c.kind = KIND_GPR;
    else
      c.drop = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Small synchronous in-order FIFO holding classified ALU results.
// The head entry is read combinationally from registered storage.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: classifies each result, buffers it in order and steers
// the head entry to the GPR port, HI/LO pair, MAR strobe or PC strobe.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [3:0]        in_dest,
  input  logic [DATA_W-1:0] in_zlow,
  input  logic [DATA_W-1:0] in_zhigh,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mar_valid,
  output logic [DATA_W-1:0] mar_data,
  output logic              pc_valid,
  output logic [DATA_W-1:0] pc_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int ENTRY_W = 2 + 4 + 2 * DATA_W;

  class_t              in_class;
  logic                accept;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  kind_t               head_kind;
  logic [3:0]          head_dest;
  logic [DATA_W-1:0]   head_zlow;
  logic [DATA_W-1:0]   head_zhigh;

  always_comb in_class = classify(in_opcode);

  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && !in_class.drop;
  assign push_entry = {in_class.kind, in_dest, in_zhigh, in_zlow};

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty)
  );

  assign head_kind  = kind_t'(head_entry[ENTRY_W-1 -: 2]);
  assign head_dest  = head_entry[2*DATA_W+3 -: 4];
  assign head_zhigh = head_entry[2*DATA_W-1 -: DATA_W];
  assign head_zlow  = head_entry[DATA_W-1:0];

  // Only GPR writes can stall the head; every other kind retires immediately.
  assign wb_valid  = !empty && (head_kind == KIND_GPR);
  assign mar_valid = !empty && (head_kind == KIND_MAR);
  assign pc_valid  = !empty && (head_kind == KIND_PC);
  assign pop       = !empty && ((head_kind != KIND_GPR) || wb_ready);

  assign wb_dest  = head_dest;
  assign wb_data  = head_zlow;
  assign mar_data = head_zlow;
  assign pc_data  = head_zlow;

  always_ff @(posedge clock) begin
    if (clear) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!empty && (head_kind == KIND_HILO)) begin
      hi_q <= head_zhigh;
      lo_q <= head_zlow;
    end
  end

  always_ff @(posedge clock) begin
    if (clear)
      drop_cnt <= '0;
    else if (accept && in_class.drop && (drop_cnt != {DROP_W{1'b1}}))
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a
// randomized stream compared against a transaction-level queue model.
module tb_alu_result_stage;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int DROP_W = 8;

  localparam int K_DROP = -1;
  localparam int K_GPR  = 0;
  localparam int K_HILO = 1;
  localparam int K_MAR  = 2;
  localparam int K_PC   = 3;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_opcode = '0;
  logic [3:0]        in_dest = '0;
  logic [DATA_W-1:0] in_zlow = '0;
  logic [DATA_W-1:0] in_zhigh = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              mar_valid;
  logic [DATA_W-1:0] mar_data;
  logic              pc_valid;
  logic [DATA_W-1:0] pc_data;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DROP_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    logic [3:0]  dest;
    logic [31:0] zlow;
    logic [31:0] zhigh;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_drop = 0;

  alu_result_stage #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .DROP_W (DROP_W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_dest   (in_dest),
    .in_zlow   (in_zlow),
    .in_zhigh  (in_zhigh),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .mar_valid (mar_valid),
    .mar_data  (mar_data),
    .pc_valid  (pc_valid),
    .pc_data   (pc_data),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Opcode table: which sink each instruction's result belongs to.
  function automatic int ref_kind(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o == 0 || o == 2) return K_MAR;
    if (o == 15 || o == 16) return K_HILO;
    if (o == 19) return K_PC;
    if (o == 1 || (o >= 3 && o <= 12) || o == 17 || o == 18) return K_GPR;
    return K_DROP;
  endfunction

  function automatic int head_kind();
    if (mq.size() == 0) return K_DROP;
    return mq[0].kind;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit   accept;
    int   k;
    ent_t e;
    if (clear) begin
      mq.delete();
      m_hi = '0;
      m_lo = '0;
      m_drop = 0;
    end else begin
      accept = in_valid && (mq.size() < DEPTH);
      if (mq.size() > 0) begin
        if (mq[0].kind == K_HILO) begin
          m_hi = mq[0].zhigh;
          m_lo = mq[0].zlow;
        end
        if (mq[0].kind != K_GPR || wb_ready) void'(mq.pop_front());
      end
      if (accept) begin
        k = ref_kind(in_opcode);
        if (k == K_DROP) begin
          if (m_drop < 255) m_drop++;
        end else begin
          e.kind = k; e.dest = in_dest; e.zlow = in_zlow; e.zhigh = in_zhigh;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [4:0] op, input logic [3:0] dest,
                          input logic [31:0] zl, input logic [31:0] zh);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = op; in_dest = dest; in_zlow = zl; in_zhigh = zh;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("[TB] FAIL push_timeout: in_ready stuck at %b, want 1 within 20 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({wb_valid, mar_valid, pc_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 000", {wb_valid, mar_valid, pc_valid}); end
    checks++; if (hi_q !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", hi_q); end
    checks++; if (lo_q !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", lo_q); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_gpr_write();
    wb_ready = 1'b1;
    push_one(5'd3, 4'd4, 32'h7, 32'h0);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL gpr_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_dest !== 4'd4) begin errors++; $display("[TB] FAIL gpr_wb_dest: got %0d want 4", wb_dest); end
    checks++; if (wb_data !== 32'h7) begin errors++; $display("[TB] FAIL gpr_wb_data: got %h want 7", wb_data); end
    checks++; if ({mar_valid, pc_valid} !== 2'b00) begin errors++; $display("[TB] FAIL gpr_other_strobes: got %b want 00", {mar_valid, pc_valid}); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL gpr_empty_after: wb_valid got %b want 0", wb_valid); end
  endtask

  task automatic test_hilo();
    push_one(5'd15, 4'd0, 32'h8000_0000, 32'h1);
    checks++; if ({wb_valid, mar_valid, pc_valid} !== 3'b000) begin errors++; $display("[TB] FAIL hilo_strobes: got %b want 000", {wb_valid, mar_valid, pc_valid}); end
    tick();
    checks++; if (hi_q !== 32'h1) begin errors++; $display("[TB] FAIL hilo_hi: got %h want 1", hi_q); end
    checks++; if (lo_q !== 32'h8000_0000) begin errors++; $display("[TB] FAIL hilo_lo: got %h want 80000000", lo_q); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL hilo_wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0]  got_dest[$];
    logic [31:0] got_data[$];
    logic [3:0]  want_dest[3];
    logic [31:0] want_data[3];
    bit acc;
    want_dest = '{4'd1, 4'd2, 4'd3};
    want_data = '{32'h11, 32'h22, 32'h33};
    wb_ready = 1'b0;
    push_one(5'd3, 4'd1, 32'h11, 32'h0);
    push_one(5'd4, 4'd2, 32'h22, 32'h0);
    in_valid = 1'b1; in_opcode = 5'd6; in_dest = 4'd3; in_zlow = 32'h33; in_zhigh = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
      checks++; if (wb_valid !== 1'b1 || wb_dest !== 4'd1 || wb_data !== 32'h11) begin
        errors++; $display("[TB] FAIL bp_hold: got v=%b d=%0d data=%h want v=1 d=1 data=11", wb_valid, wb_dest, wb_data);
      end
      tick();
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid) begin
        got_dest.push_back(wb_dest);
        got_data.push_back(wb_data);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (got_dest.size() != 3) begin errors++; $display("[TB] FAIL bp_write_count: got %0d want 3", got_dest.size()); end
    for (int i = 0; i < 3 && i < got_dest.size(); i++) begin
      checks++; if (got_dest[i] !== want_dest[i] || got_data[i] !== want_data[i]) begin
        errors++; $display("[TB] FAIL bp_order[%0d]: got d=%0d data=%h want d=%0d data=%h", i, got_dest[i], got_data[i], want_dest[i], want_data[i]);
      end
    end
  endtask

  task automatic test_mixed();
    ent_t pend[$];
    ent_t e;
    int   mar_n, pc_n, mar_cyc, pc_cyc;
    logic [31:0] mar_seen, pc_seen;
    bit   acc;
    mar_n = 0; pc_n = 0; mar_cyc = -1; pc_cyc = -1; mar_seen = '0; pc_seen = '0;
    wb_ready = 1'b1;
    e.kind = 0; e.dest = 4'd0; e.zlow = 32'h40;  e.zhigh = 32'h0; pend.push_back(e);
    e.kind = 19; e.dest = 4'd0; e.zlow = 32'h100; e.zhigh = 32'h0; pend.push_back(e);
    e.kind = 16; e.dest = 4'd0; e.zlow = 32'h5;   e.zhigh = 32'h3; pend.push_back(e);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (pend.size() > 0) begin
        in_valid = 1'b1; in_opcode = 5'(pend[0].kind); in_dest = pend[0].dest;
        in_zlow = pend[0].zlow; in_zhigh = pend[0].zhigh;
      end else begin
        in_valid = 1'b0;
      end
      checks++; if ($countones({wb_valid, mar_valid, pc_valid}) > 1) begin
        errors++; $display("[TB] FAIL mixed_one_strobe: got %b want at most one set", {wb_valid, mar_valid, pc_valid});
      end
      if (mar_valid) begin mar_n++; mar_cyc = cyc; mar_seen = mar_data; end
      if (pc_valid)  begin pc_n++;  pc_cyc = cyc;  pc_seen = pc_data;   end
      acc = in_valid && in_ready;
      tick();
      if (acc) void'(pend.pop_front());
    end
    in_valid = 1'b0;
    checks++; if (mar_n != 1 || mar_seen !== 32'h40) begin errors++; $display("[TB] FAIL mixed_mar: got n=%0d data=%h want n=1 data=40", mar_n, mar_seen); end
    checks++; if (pc_n != 1 || pc_seen !== 32'h100) begin errors++; $display("[TB] FAIL mixed_pc: got n=%0d data=%h want n=1 data=100", pc_n, pc_seen); end
    checks++; if (!(mar_cyc >= 0 && pc_cyc > mar_cyc)) begin errors++; $display("[TB] FAIL mixed_order: got mar@%0d pc@%0d want mar before pc", mar_cyc, pc_cyc); end
    checks++; if (hi_q !== 32'h3 || lo_q !== 32'h5) begin errors++; $display("[TB] FAIL mixed_hilo: got hi=%h lo=%h want hi=3 lo=5", hi_q, lo_q); end
  endtask

  task automatic test_drops();
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL drop_in_ready[%0d]: got %b want 1", i, in_ready); end
      push_one(5'd31, 4'd9, 32'hdead, 32'hbeef);
    end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("[TB] FAIL drop_count3: got %0d want 3", drop_cnt); end
    checks++; if ({wb_valid, mar_valid, pc_valid} !== 3'b000) begin errors++; $display("[TB] FAIL drop_not_stored: got %b want 000", {wb_valid, mar_valid, pc_valid}); end
    in_valid = 1'b1; in_opcode = 5'd31;
    for (int i = 0; i < 252; i++) tick();
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_count255: got %0d want 255", drop_cnt); end
    tick();
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_saturate: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    push_one(5'd3, 4'd5, 32'h55, 32'h0);
    push_one(5'd3, 4'd6, 32'h66, 32'h0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_full: in_ready got %b want 0", in_ready); end
    clear = 1'b1; in_valid = 1'b1; in_opcode = 5'd3; in_dest = 4'd7; in_zlow = 32'h77;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
    checks++; if (hi_q !== 32'h0 || lo_q !== 32'h0) begin errors++; $display("[TB] FAIL flush_hilo: got hi=%h lo=%h want 0 0", hi_q, lo_q); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL flush_drop: got %0d want 0", drop_cnt); end
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({wb_valid, mar_valid, pc_valid} !== 3'b000) begin errors++; $display("[TB] FAIL flush_no_write[%0d]: got %b want 000", i, {wb_valid, mar_valid, pc_valid}); end
      tick();
    end
  endtask

  task automatic test_random();
    bit acc;
    bit was_clear;
    int hk;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_opcode = 5'($urandom_range(0, 31));
        in_dest = 4'($urandom_range(0, 15));
        in_zlow = $urandom;
        in_zhigh = $urandom;
      end
      wb_ready = ($urandom_range(0, 9) < 6);
      clear = ($urandom_range(0, 59) == 0);
      hk = head_kind();
      checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, mq.size() < DEPTH); end
      checks++; if ({wb_valid, mar_valid, pc_valid} !== {hk == K_GPR, hk == K_MAR, hk == K_PC}) begin
        errors++; $display("[TB] FAIL rnd_strobes@%0d: got %b want %b", cyc, {wb_valid, mar_valid, pc_valid}, {hk == K_GPR, hk == K_MAR, hk == K_PC});
      end
      if (hk == K_GPR) begin
        checks++; if (wb_dest !== mq[0].dest || wb_data !== mq[0].zlow) begin
          errors++; $display("[TB] FAIL rnd_wb@%0d: got d=%0d data=%h want d=%0d data=%h", cyc, wb_dest, wb_data, mq[0].dest, mq[0].zlow);
        end
      end
      if (hk == K_MAR) begin
        checks++; if (mar_data !== mq[0].zlow) begin errors++; $display("[TB] FAIL rnd_mar@%0d: got %h want %h", cyc, mar_data, mq[0].zlow); end
      end
      if (hk == K_PC) begin
        checks++; if (pc_data !== mq[0].zlow) begin errors++; $display("[TB] FAIL rnd_pc@%0d: got %h want %h", cyc, pc_data, mq[0].zlow); end
      end
      checks++; if (hi_q !== m_hi || lo_q !== m_lo) begin errors++; $display("[TB] FAIL rnd_hilo@%0d: got hi=%h lo=%h want hi=%h lo=%h", cyc, hi_q, lo_q, m_hi, m_lo); end
      checks++; if (int'(drop_cnt) != m_drop) begin errors++; $display("[TB] FAIL rnd_drop@%0d: got %0d want %0d", cyc, drop_cnt, m_drop); end
      acc = in_valid && in_ready;
      was_clear = clear;
      tick();
      if (acc || was_clear) in_valid = 1'b0;
    end
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_hilo();
    test_backpressure();
    test_mixed();
    test_drops();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
